// File: rtl/wb_stage_pkg.sv
// Shared encodings and types for the writeback stage and its load extender.
// Pure declarations plus one combinational helper; no state.
package wb_stage_pkg;

  localparam int XLEN = 32;
  localparam int RD_W = 5;

  localparam logic [1:0] RS_ALU = 2'b00;
  localparam logic [1:0] RS_MEM = 2'b01;
  localparam logic [1:0] RS_PC4 = 2'b10;
  localparam logic [1:0] RS_IMM = 2'b11;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    WAIT_MEM = 2'b01,
    WRITE    = 2'b10
  } wb_state_e;

  // Everything a pending load still needs once the upstream payload has moved on.
  typedef struct packed {
    logic [RD_W-1:0] rd;
    logic            we;
    logic [2:0]      funct3;
    logic [1:0]      off;
  } load_ctx_t;

  function automatic logic [XLEN-1:0] pick_result(
    input logic [1:0]      src,
    input logic [XLEN-1:0] alu,
    input logic [XLEN-1:0] pc4,
    input logic [XLEN-1:0] imm
  );
    logic [XLEN-1:0] res;
    case (src)
      RS_PC4:  res = pc4;
      RS_IMM:  res = imm;
      default: res = alu;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/wb_stage_if.sv
// EX/MEM -> writeback instruction handshake: valid/ready plus the retiring payload.
// Master is the EX/MEM side; slave is the writeback stage, which owns in_ready.
interface wb_stage_if;
  import wb_stage_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic            in_reg_write;
  logic [RD_W-1:0] in_rd;
  logic [1:0]      in_result_src;
  logic [2:0]      in_funct3;
  logic [XLEN-1:0] in_alu_result;
  logic [XLEN-1:0] in_pc_plus_4;
  logic [XLEN-1:0] in_imm;

  modport master (
    output in_valid, in_reg_write, in_rd, in_result_src, in_funct3,
           in_alu_result, in_pc_plus_4, in_imm,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_reg_write, in_rd, in_result_src, in_funct3,
           in_alu_result, in_pc_plus_4, in_imm,
    output in_ready
  );

endinterface

// File: rtl/wb_stage_load_extend.sv
// Load alignment and sign/zero extension of a 32-bit memory word, plus misalign detect.
// Purely combinational; no handshake.
module load_extend
  import wb_stage_pkg::*;
(
  input  logic [2:0]      funct3,
  input  logic [1:0]      off,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] data,
  output logic            misalign
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = rdata[7:0];
    case (off)
      2'd1:    byte_v = rdata[15:8];
      2'd2:    byte_v = rdata[23:16];
      2'd3:    byte_v = rdata[31:24];
      default: byte_v = rdata[7:0];
    endcase
    half_v = off[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    data     = '0;
    misalign = 1'b0;
    case (funct3)
      F3_LB:  data = {{24{byte_v[7]}}, byte_v};
      F3_LBU: data = {24'd0, byte_v};
      F3_LH: begin
        data     = {{16{half_v[15]}}, half_v};
        misalign = off[0];
      end
      F3_LHU: begin
        data     = {16'd0, half_v};
        misalign = off[0];
      end
      F3_LW: begin
        data     = rdata;
        misalign = (off != 2'd0);
      end
      // Reserved load encodings are treated like a misaligned access.
      default: misalign = 1'b1;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: one-cycle register-file write per retired instruction, loads wait for dmem.
// 1 cycle transfer->write for non-loads; in_ready drops only while a load waits on memory.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                 clk,
  input  logic                 n_rst,
  wb_stage_if.slave            in_if,
  input  logic                 dmem_rvalid,
  input  logic [XLEN-1:0]      dmem_rdata,
  output logic                 RegWrite,
  output logic [RD_W-1:0]      rd,
  output logic [XLEN-1:0]      reg_wdata,
  output logic [CNT_WIDTH-1:0] retire_cnt,
  output logic                 misalign_err,
  output logic                 timeout_err
);

  localparam int            TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES);

  wb_state_e            state_q, state_d;
  load_ctx_t            ctx_q, ctx_d;
  logic [TW-1:0]        tmo_cnt_q, tmo_cnt_d;
  logic [RD_W-1:0]      rd_q, rd_d;
  logic [XLEN-1:0]      wdata_q, wdata_d;
  logic                 we_q, we_d;
  logic [CNT_WIDTH-1:0] retire_cnt_q, retire_cnt_d;
  logic                 misalign_err_q, misalign_err_d;
  logic                 timeout_err_q, timeout_err_d;

  logic                 xfer;
  logic                 in_is_load;
  logic [TW-1:0]        tmo_cnt_inc;
  logic [2:0]           ext_funct3;
  logic [1:0]           ext_off;
  logic [XLEN-1:0]      ext_data;
  logic                 ext_misalign;

  assign in_if.in_ready = (state_q != WAIT_MEM);
  assign xfer           = in_if.in_valid & in_if.in_ready;
  assign in_is_load     = (in_if.in_result_src == RS_MEM);
  assign tmo_cnt_inc    = tmo_cnt_q + TW'(1);

  // One extender serves both jobs: misalign check on the incoming load while
  // accepting, data extension of the captured load while waiting on memory.
  assign ext_funct3 = (state_q == WAIT_MEM) ? ctx_q.funct3 : in_if.in_funct3;
  assign ext_off    = (state_q == WAIT_MEM) ? ctx_q.off    : in_if.in_alu_result[1:0];

  load_extend u_load_extend (
    .funct3   (ext_funct3),
    .off      (ext_off),
    .rdata    (dmem_rdata),
    .data     (ext_data),
    .misalign (ext_misalign)
  );

  always_comb begin
    state_d        = state_q;
    ctx_d          = ctx_q;
    tmo_cnt_d      = tmo_cnt_q;
    rd_d           = rd_q;
    wdata_d        = wdata_q;
    we_d           = we_q;
    misalign_err_d = misalign_err_q;
    timeout_err_d  = timeout_err_q;
    retire_cnt_d   = (state_q == WRITE) ? retire_cnt_q + CNT_WIDTH'(1) : retire_cnt_q;

    case (state_q)
      IDLE, WRITE: begin
        state_d = IDLE;
        if (xfer) begin
          if (in_is_load) begin
            if (ext_misalign) begin
              misalign_err_d = 1'b1;
            end else begin
              state_d      = WAIT_MEM;
              tmo_cnt_d    = '0;
              ctx_d.rd     = in_if.in_rd;
              ctx_d.we     = in_if.in_reg_write & (in_if.in_rd != '0);
              ctx_d.funct3 = in_if.in_funct3;
              ctx_d.off    = in_if.in_alu_result[1:0];
            end
          end else begin
            state_d = WRITE;
            rd_d    = in_if.in_rd;
            we_d    = in_if.in_reg_write & (in_if.in_rd != '0);
            wdata_d = pick_result(in_if.in_result_src, in_if.in_alu_result,
                                  in_if.in_pc_plus_4, in_if.in_imm);
          end
        end
      end

      WAIT_MEM: begin
        // Data arriving on the expiry cycle still wins over the timeout.
        if (dmem_rvalid) begin
          state_d   = WRITE;
          tmo_cnt_d = '0;
          rd_d      = ctx_q.rd;
          we_d      = ctx_q.we;
          wdata_d   = ext_data;
        end else if (tmo_cnt_inc == TMO_LAST) begin
          state_d       = IDLE;
          tmo_cnt_d     = '0;
          timeout_err_d = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_inc;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q        <= IDLE;
      ctx_q          <= '0;
      tmo_cnt_q      <= '0;
      rd_q           <= '0;
      wdata_q        <= '0;
      we_q           <= 1'b0;
      retire_cnt_q   <= '0;
      misalign_err_q <= 1'b0;
      timeout_err_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      ctx_q          <= ctx_d;
      tmo_cnt_q      <= tmo_cnt_d;
      rd_q           <= rd_d;
      wdata_q        <= wdata_d;
      we_q           <= we_d;
      retire_cnt_q   <= retire_cnt_d;
      misalign_err_q <= misalign_err_d;
      timeout_err_q  <= timeout_err_d;
    end
  end

  assign RegWrite     = (state_q == WRITE) & we_q;
  assign rd           = rd_q;
  assign reg_wdata    = wdata_q;
  assign retire_cnt   = retire_cnt_q;
  assign misalign_err = misalign_err_q;
  assign timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: expected register writes are queued at issue and
// checked by an independent monitor; flags, counters and handshake checked inline.
module tb_wb_stage;

  logic        clk;
  logic        n_rst;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        RegWrite;
  logic [4:0]  rd;
  logic [31:0] reg_wdata;
  logic [31:0] retire_cnt;
  logic        misalign_err;
  logic        timeout_err;

  wb_stage_if bus ();

  wb_stage #(.TIMEOUT_CYCLES(16), .CNT_WIDTH(32)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .in_if        (bus),
    .dmem_rvalid  (dmem_rvalid),
    .dmem_rdata   (dmem_rdata),
    .RegWrite     (RegWrite),
    .rd           (rd),
    .reg_wdata    (reg_wdata),
    .retire_cnt   (retire_cnt),
    .misalign_err (misalign_err),
    .timeout_err  (timeout_err)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_err    = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_wr(input logic [4:0] r, input logic [31:0] d);
    exp_t e;
    e.rd   = r;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Presents one instruction and returns #1 after the edge that transferred it.
  // in_valid is left asserted so callers can chain back-to-back transfers.
  task automatic send(input logic [4:0] r, input logic [1:0] src, input logic [2:0] f3,
                      input logic [31:0] alu, input logic [31:0] pc4, input logic [31:0] imm,
                      input logic regw);
    int waited;
    bus.in_valid      = 1'b1;
    bus.in_rd         = r;
    bus.in_result_src = src;
    bus.in_funct3     = f3;
    bus.in_alu_result = alu;
    bus.in_pc_plus_4  = pc4;
    bus.in_imm        = imm;
    bus.in_reg_write  = regw;
    waited = 0;
    while (bus.in_ready !== 1'b1 && waited < 64) begin
      tick();
      waited++;
    end
    if (waited >= 64) begin
      n_checks++;
      n_err++;
      $display("FAIL send_ready_timeout: in_ready=%b after %0d cycles, expected 1", bus.in_ready, waited);
    end
    tick();
  endtask

  task automatic drop();
    bus.in_valid = 1'b0;
  endtask

  // rvalid is seen by the DUT on the dly-th edge after the load transfer.
  task automatic load_resp(input int dly, input logic [31:0] d);
    repeat (dly - 1) tick();
    dmem_rvalid = 1'b1;
    dmem_rdata  = d;
    tick();
    dmem_rvalid = 1'b0;
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (RegWrite === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL sb_unexpected: RegWrite=1 rd=%0d wdata=%08h, expected no write", rd, reg_wdata);
      end else begin
        e = exp_q.pop_front();
        chk("sb_rd", 64'(rd), 64'(e.rd));
        chk("sb_wdata", 64'(reg_wdata), 64'(e.data));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    n_rst             = 1'b0;
    dmem_rvalid       = 1'b0;
    dmem_rdata        = 32'h0;
    bus.in_valid      = 1'b0;
    bus.in_rd         = '0;
    bus.in_result_src = '0;
    bus.in_funct3     = '0;
    bus.in_alu_result = '0;
    bus.in_pc_plus_4  = '0;
    bus.in_imm        = '0;
    bus.in_reg_write  = 1'b0;
    tick();
    tick();
    n_rst = 1'b1;

    chk("rst_regwrite", 64'(RegWrite), 64'd0);
    chk("rst_rd", 64'(rd), 64'd0);
    chk("rst_wdata", 64'(reg_wdata), 64'd0);
    chk("rst_retire", 64'(retire_cnt), 64'd0);
    chk("rst_misalign", 64'(misalign_err), 64'd0);
    chk("rst_timeout", 64'(timeout_err), 64'd0);
    chk("rst_ready", 64'(bus.in_ready), 64'd1);

    // ALU write, visible the cycle after transfer for exactly one cycle
    expect_wr(5'd5, 32'hDEADBEEF);
    send(5'd5, 2'b00, 3'b000, 32'hDEADBEEF, 32'h0, 32'h0, 1'b1);
    drop();
    chk("alu_regwrite", 64'(RegWrite), 64'd1);
    chk("alu_rd", 64'(rd), 64'd5);
    chk("alu_wdata", 64'(reg_wdata), 64'hDEADBEEF);
    tick();
    chk("alu_regwrite_drop", 64'(RegWrite), 64'd0);
    chk("alu_retire", 64'(retire_cnt), 64'd1);

    // LB at offset 3, data three cycles later
    expect_wr(5'd7, 32'hFFFFFF80);
    send(5'd7, 2'b01, 3'b000, 32'h00001003, 32'h0, 32'h0, 1'b1);
    drop();
    chk("lb_ready_low", 64'(bus.in_ready), 64'd0);
    chk("lb_no_write_wait", 64'(RegWrite), 64'd0);
    load_resp(3, 32'h80AA55CC);
    chk("lb_wdata", 64'(reg_wdata), 64'hFFFFFF80);
    tick();
    chk("lb_ready_back", 64'(bus.in_ready), 64'd1);

    // LBU, same stimulus
    expect_wr(5'd8, 32'h00000080);
    send(5'd8, 2'b01, 3'b100, 32'h00001003, 32'h0, 32'h0, 1'b1);
    drop();
    load_resp(3, 32'h80AA55CC);
    chk("lbu_wdata", 64'(reg_wdata), 64'h00000080);
    tick();
    chk("lbu_retire", 64'(retire_cnt), 64'd3);

    // Misaligned LW dropped, following ALU instruction accepted straight away
    send(5'd9, 2'b01, 3'b010, 32'h00001002, 32'h0, 32'h0, 1'b1);
    chk("mis_flag", 64'(misalign_err), 64'd1);
    chk("mis_no_write", 64'(RegWrite), 64'd0);
    chk("mis_ready", 64'(bus.in_ready), 64'd1);
    chk("mis_retire", 64'(retire_cnt), 64'd3);
    expect_wr(5'd10, 32'h12345678);
    send(5'd10, 2'b00, 3'b000, 32'h12345678, 32'h0, 32'h0, 1'b1);
    drop();
    chk("mis_next_write", 64'(RegWrite), 64'd1);
    tick();
    chk("mis_next_retire", 64'(retire_cnt), 64'd4);

    // LH at offset 2, then aligned LW
    expect_wr(5'd11, 32'hFFFF80AA);
    send(5'd11, 2'b01, 3'b001, 32'h00002002, 32'h0, 32'h0, 1'b1);
    drop();
    load_resp(1, 32'h80AA55CC);
    tick();
    expect_wr(5'd12, 32'h80AA55CC);
    send(5'd12, 2'b01, 3'b010, 32'h00002000, 32'h0, 32'h0, 1'b1);
    drop();
    load_resp(2, 32'h80AA55CC);
    tick();
    chk("lhw_retire", 64'(retire_cnt), 64'd6);

    // PC+4 and immediate selects back to back
    expect_wr(5'd13, 32'h00000104);
    send(5'd13, 2'b10, 3'b000, 32'hAAAAAAAA, 32'h00000104, 32'hBBBBBBBB, 1'b1);
    expect_wr(5'd14, 32'hABCDE000);
    send(5'd14, 2'b11, 3'b000, 32'hAAAAAAAA, 32'h00000104, 32'hABCDE000, 1'b1);
    drop();
    tick();
    chk("sel_retire", 64'(retire_cnt), 64'd8);

    // rvalid on the 16th waiting cycle still completes the load
    expect_wr(5'd16, 32'hCAFEF00D);
    send(5'd16, 2'b01, 3'b010, 32'h00003004, 32'h0, 32'h0, 1'b1);
    drop();
    load_resp(16, 32'hCAFEF00D);
    chk("edge16_write", 64'(RegWrite), 64'd1);
    chk("edge16_no_tmo", 64'(timeout_err), 64'd0);
    tick();
    chk("edge16_retire", 64'(retire_cnt), 64'd9);

    // No rvalid: abandoned after 16 waiting cycles
    send(5'd15, 2'b01, 3'b010, 32'h00003000, 32'h0, 32'h0, 1'b1);
    drop();
    repeat (15) tick();
    chk("tmo_still_wait", 64'(bus.in_ready), 64'd0);
    chk("tmo_not_yet", 64'(timeout_err), 64'd0);
    tick();
    chk("tmo_flag", 64'(timeout_err), 64'd1);
    chk("tmo_idle_ready", 64'(bus.in_ready), 64'd1);
    chk("tmo_retire", 64'(retire_cnt), 64'd9);

    // x0 write suppressed but retired; consecutive retirements
    send(5'd0, 2'b00, 3'b000, 32'h00000011, 32'h0, 32'h0, 1'b1);
    chk("b2b_we0", 64'(RegWrite), 64'd0);
    expect_wr(5'd1, 32'h00000022);
    send(5'd1, 2'b00, 3'b000, 32'h00000022, 32'h0, 32'h0, 1'b1);
    chk("b2b_we1", 64'(RegWrite), 64'd1);
    expect_wr(5'd2, 32'h00000033);
    send(5'd2, 2'b00, 3'b000, 32'h00000033, 32'h0, 32'h0, 1'b1);
    chk("b2b_we2", 64'(RegWrite), 64'd1);
    expect_wr(5'd3, 32'h00000044);
    send(5'd3, 2'b00, 3'b000, 32'h00000044, 32'h0, 32'h0, 1'b1);
    drop();
    chk("b2b_we3", 64'(RegWrite), 64'd1);
    tick();
    chk("b2b_retire", 64'(retire_cnt), 64'd13);

    // Reset while waiting on memory; the late response must not write
    send(5'd20, 2'b01, 3'b010, 32'h00004000, 32'h0, 32'h0, 1'b1);
    drop();
    tick();
    tick();
    n_rst = 1'b0;
    tick();
    n_rst = 1'b1;
    chk("mrst_regwrite", 64'(RegWrite), 64'd0);
    chk("mrst_rd", 64'(rd), 64'd0);
    chk("mrst_wdata", 64'(reg_wdata), 64'd0);
    chk("mrst_retire", 64'(retire_cnt), 64'd0);
    chk("mrst_misalign", 64'(misalign_err), 64'd0);
    chk("mrst_timeout", 64'(timeout_err), 64'd0);
    chk("mrst_ready", 64'(bus.in_ready), 64'd1);
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h55555555;
    tick();
    dmem_rvalid = 1'b0;
    chk("mrst_late_rvalid", 64'(RegWrite), 64'd0);
    tick();
    chk("mrst_late_retire", 64'(retire_cnt), 64'd0);

    chk("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Writeback stage for the single-cycle RISC-V core; the write-side counterpart to ID_stage's register-file read port.
- Accepts completed instructions from EX/MEM over a valid/ready handshake and waits for load data from data memory.
- Aligns and sign/zero-extends load data, then drives the register-file write port (RegWrite, rd, reg_wdata) for exactly one cycle per instruction.
- Also counts retired instructions and flags load errors.

Parameters:
- TIMEOUT_CYCLES, 16: maximum cycles spent in WAIT_MEM before the load is abandoned.
- CNT_WIDTH, 32: width of retire_cnt.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- n_rst  input  1  reset, synchronous, active-low.
- in_valid  input  1  EX/MEM holds a valid instruction.
- in_ready  output  1  stage can accept; high in IDLE and WRITE, low in WAIT_MEM.
- in_reg_write  input  1  instruction writes rd.
- in_rd  input  5  destination register.
- in_result_src  input  2  00 ALU, 01 load, 10 PC+4, 11 immediate.
- in_funct3  input  3  load width/sign (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU).
- in_alu_result  input  32  ALU result / load byte address.
- in_pc_plus_4  input  32  link value.
- in_imm  input  32  extended immediate (LUI).
- dmem_rvalid  input  1  load data valid this cycle.
- dmem_rdata  input  32  aligned 32-bit word from data memory.
- RegWrite  output  1  register-file write enable.
- rd  output  5  register-file write address.
- reg_wdata  output  32  register-file write data.
- retire_cnt  output  CNT_WIDTH  completed WRITE count.
- misalign_err  output  1  sticky; misaligned or illegal load seen.
- timeout_err  output  1  sticky; load timed out.

Behaviour:
- Reset: synchronous on posedge clk while n_rst=0.
  - State goes to IDLE.
  - RegWrite=0, rd=0, reg_wdata=0, retire_cnt=0, both error flags 0, timeout counter 0.
  - Handshakes are ignored while n_rst=0.
  - Reset mid-WAIT_MEM abandons the load with no write.
- Transfer: occurs when in_valid & in_ready at posedge. The capture register latches rd, reg_write, result_src, funct3, alu_result, pc_plus_4, imm.
- FSM transitions:
  - IDLE: on transfer, go to WAIT_MEM if result_src=01, else to WRITE.
  - WAIT_MEM: the timeout counter increments each cycle.
    - When dmem_rvalid=1, latch the extended data and go to WRITE.
    - When the counter reaches TIMEOUT_CYCLES without rvalid, set timeout_err, go to IDLE, no write.
    - rvalid in the same cycle as the counter expiry counts as success.
  - WRITE: registered outputs are presented for this one cycle.
    - If a transfer also occurs, go to WAIT_MEM/WRITE per the new result_src; otherwise go to IDLE.
    - Back-to-back non-load instructions therefore retire one per cycle after the first.
- Write port:
  - RegWrite = 1 only in WRITE and only when the captured reg_write=1 and rd≠0.
  - In all other states RegWrite=0. rd and reg_wdata are held stable outside WRITE.
- Data select: ALU → alu_result; PC+4 → pc_plus_4; IMM → imm; LOAD → extended load data.
- Load extension, with byte offset off = alu_result[1:0]:
  - LB/LBU: byte dmem_rdata[8*off+7:8*off], sign- or zero-extended.
  - LH/LHU: half at off[1]; off[0]=1 is misaligned.
  - LW: off≠0 is misaligned.
- Load errors:
  - Misaligned loads and funct3 ∈ {011,110,111} set misalign_err at capture and go to IDLE, no write.
  - in_ready stays high, so a new transfer is accepted the same cycle.
- retire_cnt: increments by 1 on every WRITE cycle, including rd=0 or reg_write=0 cases. Wraps modulo 2^CNT_WIDTH. Dropped instructions do not count.
- Error flags are cleared only by reset.

Decomposition:
- Shared package: RESULT_SRC encodings (RS_ALU, RS_MEM, RS_PC4, RS_IMM), load funct3 constants (F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU), FSM state encodings (IDLE, WAIT_MEM, WRITE).
- One sub-module, load_extend: combinational funct3/offset/rdata → 32-bit data plus misalign flag. It reuses the same constants and is unit-testable on its own.

Test Plan:
- ALU write: transfer rd=5, result_src=00, alu_result=0xDEADBEEF, reg_write=1 → next cycle RegWrite=1, rd=5, reg_wdata=0xDEADBEEF for one cycle; retire_cnt=1.
- LB sign-extend: addr=0x1003, funct3=000, rdata=0x80AA55CC, rvalid 3 cycles later → reg_wdata=0xFFFFFF80. LBU same stimulus → 0x00000080. in_ready=0 while in WAIT_MEM.
- Misaligned LW: addr=0x1002, funct3=010 → misalign_err=1, RegWrite never asserts, retire_cnt unchanged. A following ALU instruction still retires.
- Timeout: load issued, rvalid held 0 → after 16 cycles timeout_err=1, state IDLE, no write. rvalid arriving exactly at cycle 16 → write occurs, no error.
- x0 and back-to-back: four consecutive ALU transfers with rd=0,1,2,3 → RegWrite pattern 0,1,1,1 on consecutive cycles; retire_cnt=4.
- Reset mid-load: n_rst=0 for one cycle during WAIT_MEM → all outputs 0, state IDLE; a late rvalid causes no write.
